cvrp_run_scheduler: RTL and testbench

- Parametrised successor of the CVRP controller: sequences the initial-solution phase and the improvement phase across a configurable array of processing nodes.
- Dispatches runs one per cycle to idle nodes over a start/done handshake, collects per-node route costs, and tracks the best solution.
- Sits between the top-level run control and the processing-node array.

---
 rtl/cvrp_run_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_cvrp_run_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvrp_run_scheduler.sv
// cvrp_run_scheduler: sequences the init and improvement phases across an array of
// processing nodes, dispatching one run per cycle and tracking the best route cost.
module cvrp_run_scheduler #(
  parameter int pNumProcessingNodes = 16,
  parameter int pNumInitRuns        = 20,
  parameter int pNumRuns            = 68,
  parameter int pCostWidth          = 24,
  parameter int pRunIdWidth         = 8
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      start_i,
  input  logic                                      abort_i,
  output logic [pNumProcessingNodes-1:0]            node_start_o,
  output logic                                      node_mode_o,
  output logic [pRunIdWidth-1:0]                    node_run_id_o,
  input  logic [pNumProcessingNodes-1:0]            node_done_i,
  input  logic [pNumProcessingNodes*pCostWidth-1:0] node_cost_i,
  output logic                                      busy_o,
  output logic [1:0]                                phase_o,
  output logic                                      done_o,
  output logic                                      aborted_o,
  output logic [pCostWidth-1:0]                     best_cost_o,
  output logic [5:0]                                best_node_o,
  output logic [pRunIdWidth-1:0]                    best_run_o,
  output logic [pRunIdWidth:0]                      runs_completed_o,
  output logic                                      err_o
);
  localparam int N    = pNumProcessingNodes;
  localparam int CW   = pCostWidth;
  localparam int RW   = pRunIdWidth;
  localparam int CNTW = RW + 1;
  localparam logic [CNTW-1:0] INIT_RUNS  = CNTW'(pNumInitRuns);
  localparam logic [CNTW-1:0] TOTAL_RUNS = CNTW'(pNumInitRuns + pNumRuns);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_INIT_DRAIN, S_IMPR, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   issued_q, issued_d;
  logic [N-1:0]      busy_q, busy_d;
  logic [N-1:0]      pending_q, pending_d;
  logic [CW-1:0]     cost_q [N];
  logic [CW-1:0]     cost_d [N];
  logic [RW-1:0]     nrun_q [N];
  logic [RW-1:0]     nrun_d [N];
  logic [N-1:0]      node_start_q, node_start_d;
  logic              node_mode_q, node_mode_d;
  logic [RW-1:0]     node_run_id_q, node_run_id_d;
  logic [CW-1:0]     best_cost_q, best_cost_d;
  logic [5:0]        best_node_q, best_node_d;
  logic [RW-1:0]     best_run_q, best_run_d;
  logic [CNTW-1:0]   runs_completed_q, runs_completed_d;
  logic              aborted_q, aborted_d;
  logic              abort_req_q, abort_req_d;
  logic              err_q, err_d;

  logic              accept_start, do_abort, in_init, in_impr, dispatch_en;
  logic              consumed, dispatched;
  logic [CNTW-1:0]   issued_base;

  always_comb begin
    state_d          = state_q;
    issued_d         = issued_q;
    busy_d           = busy_q;
    pending_d        = pending_q;
    cost_d           = cost_q;
    nrun_d           = nrun_q;
    node_start_d     = '0;
    node_mode_d      = node_mode_q;
    node_run_id_d    = node_run_id_q;
    best_cost_d      = best_cost_q;
    best_node_d      = best_node_q;
    best_run_d       = best_run_q;
    runs_completed_d = runs_completed_q;
    aborted_d        = aborted_q;
    abort_req_d      = abort_req_q;
    err_d            = err_q;
    consumed         = 1'b0;
    dispatched       = 1'b0;

    accept_start = (state_q == S_IDLE) && start_i;
    do_abort     = abort_i && (state_q != S_IDLE) && (state_q != S_DONE);
    issued_base  = accept_start ? '0 : issued_q;
    in_init      = (state_q == S_INIT) || (accept_start && (pNumInitRuns != 0));
    in_impr      = (state_q == S_IMPR) || (accept_start && (pNumInitRuns == 0));
    // Issue counts only ever climb to the phase limit, so inequality is the stop test.
    dispatch_en  = !do_abort && ((in_init && (issued_base != INIT_RUNS)) ||
                                 (in_impr && (issued_base != TOTAL_RUNS)));

    if (accept_start) begin
      issued_d         = '0;
      best_cost_d      = '1;
      best_node_d      = '0;
      best_run_d       = '0;
      runs_completed_d = '0;
      aborted_d        = 1'b0;
      abort_req_d      = 1'b0;
      err_d            = 1'b0;
    end

    for (int n = 0; n < N; n++) begin
      if (node_done_i[n]) begin
        if (busy_q[n]) begin
          busy_d[n]    = 1'b0;
          pending_d[n] = 1'b1;
          cost_d[n]    = node_cost_i[n*CW +: CW];
        end else begin
          err_d = 1'b1;
        end
      end
    end

    // Consumption reads the registered pending set, so a result is taken no
    // earlier than the cycle after it was captured.
    for (int n = 0; n < N; n++) begin
      if (!consumed && pending_q[n]) begin
        consumed         = 1'b1;
        pending_d[n]     = 1'b0;
        runs_completed_d = runs_completed_q + 1'b1;
        if (cost_q[n] < best_cost_q) begin
          best_cost_d = cost_q[n];
          best_node_d = 6'(n);
          best_run_d  = nrun_q[n];
        end
      end
    end

    for (int n = 0; n < N; n++) begin
      if (dispatch_en && !dispatched && !busy_q[n] && !pending_q[n]) begin
        dispatched      = 1'b1;
        node_start_d[n] = 1'b1;
        busy_d[n]       = 1'b1;
        nrun_d[n]       = issued_base[RW-1:0];
      end
    end
    if (dispatched) begin
      node_mode_d   = in_impr;
      node_run_id_d = issued_base[RW-1:0];
      issued_d      = issued_base + 1'b1;
    end

    if (do_abort) abort_req_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept_start) begin
          if (pNumInitRuns == 0) state_d = (issued_d == TOTAL_RUNS) ? S_DRAIN : S_IMPR;
          else                   state_d = (issued_d == INIT_RUNS) ? S_INIT_DRAIN : S_INIT;
        end
      end
      S_INIT: begin
        if (do_abort)                    state_d = S_DRAIN;
        else if (issued_d == INIT_RUNS)  state_d = S_INIT_DRAIN;
      end
      S_INIT_DRAIN: begin
        if (do_abort)                            state_d = S_DRAIN;
        else if (runs_completed_q == INIT_RUNS)  state_d = S_IMPR;
      end
      S_IMPR: begin
        if (do_abort)                    state_d = S_DRAIN;
        else if (issued_d == TOTAL_RUNS) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((busy_q == '0) && (pending_q == '0)) begin
          state_d   = S_DONE;
          aborted_d = abort_req_q | abort_i;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= S_IDLE;
      issued_q         <= '0;
      busy_q           <= '0;
      pending_q        <= '0;
      cost_q           <= '{default: '0};
      nrun_q           <= '{default: '0};
      node_start_q     <= '0;
      node_mode_q      <= 1'b0;
      node_run_id_q    <= '0;
      best_cost_q      <= '1;
      best_node_q      <= '0;
      best_run_q       <= '0;
      runs_completed_q <= '0;
      aborted_q        <= 1'b0;
      abort_req_q      <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      issued_q         <= issued_d;
      busy_q           <= busy_d;
      pending_q        <= pending_d;
      cost_q           <= cost_d;
      nrun_q           <= nrun_d;
      node_start_q     <= node_start_d;
      node_mode_q      <= node_mode_d;
      node_run_id_q    <= node_run_id_d;
      best_cost_q      <= best_cost_d;
      best_node_q      <= best_node_d;
      best_run_q       <= best_run_d;
      runs_completed_q <= runs_completed_d;
      aborted_q        <= aborted_d;
      abort_req_q      <= abort_req_d;
      err_q            <= err_d;
    end
  end

  assign node_start_o     = node_start_q;
  assign node_mode_o      = node_mode_q;
  assign node_run_id_o    = node_run_id_q;
  assign busy_o           = (state_q != S_IDLE);
  assign phase_o          = (state_q == S_IDLE) ? 2'd0 :
                            ((state_q == S_INIT) || (state_q == S_INIT_DRAIN)) ? 2'd1 :
                            (state_q == S_IMPR) ? 2'd2 : 2'd3;
  assign done_o           = (state_q == S_DONE);
  assign aborted_o        = aborted_q;
  assign best_cost_o      = best_cost_q;
  assign best_node_o      = best_node_q;
  assign best_run_o       = best_run_q;
  assign runs_completed_o = runs_completed_q;
  assign err_o            = err_q;
endmodule

// File: tb/tb_cvrp_run_scheduler.sv
// Scoreboard bench for cvrp_run_scheduler: expected dispatches and completions are
// queued by the stimulus and checked by monitors as the DUT presents them.
module tb_cvrp_run_scheduler;
  localparam int N  = 4;
  localparam int CW = 24;
  localparam int RW = 8;

  typedef struct packed {
    logic [N-1:0]  node_oh;
    logic          mode;
    logic [RW-1:0] run;
  } disp_t;

  typedef struct packed {
    logic [CW-1:0] cost;
    logic [5:0]    node;
    logic [RW-1:0] run;
    logic [RW:0]   rc;
    logic          ab;
    logic          er;
  } fin_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, start, abort, start_b, abort_b;
  logic [N-1:0]    node_start, node_done, node_start_b, node_done_b;
  logic            node_mode, node_mode_b;
  logic [RW-1:0]   node_run_id, node_run_id_b;
  logic [N*CW-1:0] node_cost, node_cost_b;
  logic            busy, done, aborted, err, busy_b, done_b, aborted_b, err_b;
  logic [1:0]      phase, phase_b;
  logic [CW-1:0]   best_cost, best_cost_b;
  logic [5:0]      best_node, best_node_b;
  logic [RW-1:0]   best_run, best_run_b;
  logic [RW:0]     runs_completed, runs_completed_b;

  cvrp_run_scheduler #(.pNumProcessingNodes(N), .pNumInitRuns(6), .pNumRuns(10),
                       .pCostWidth(CW), .pRunIdWidth(RW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .node_start_o(node_start), .node_mode_o(node_mode), .node_run_id_o(node_run_id),
    .node_done_i(node_done), .node_cost_i(node_cost),
    .busy_o(busy), .phase_o(phase), .done_o(done), .aborted_o(aborted),
    .best_cost_o(best_cost), .best_node_o(best_node), .best_run_o(best_run),
    .runs_completed_o(runs_completed), .err_o(err));

  cvrp_run_scheduler #(.pNumProcessingNodes(N), .pNumInitRuns(0), .pNumRuns(3),
                       .pCostWidth(CW), .pRunIdWidth(RW)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .abort_i(abort_b),
    .node_start_o(node_start_b), .node_mode_o(node_mode_b), .node_run_id_o(node_run_id_b),
    .node_done_i(node_done_b), .node_cost_i(node_cost_b),
    .busy_o(busy_b), .phase_o(phase_b), .done_o(done_b), .aborted_o(aborted_b),
    .best_cost_o(best_cost_b), .best_node_o(best_node_b), .best_run_o(best_run_b),
    .runs_completed_o(runs_completed_b), .err_o(err_b));

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int done_cnt_b = 0;
  logic seen_b_phase1 = 1'b0;

  disp_t disp_q[$];
  disp_t disp_qb[$];
  fin_t  fin_q[$];
  fin_t  fin_qb[$];

  int            dly [N];
  logic [CW-1:0] ctab [N];
  logic          use_tab;
  logic [N-1:0]  spur_req;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_fin(input string tag, input fin_t e, input logic [CW-1:0] c,
                         input logic [5:0] nd, input logic [RW-1:0] r, input logic [RW:0] rc,
                         input logic ab, input logic er);
    chk({tag, "_best_cost"}, 64'(c), 64'(e.cost));
    chk({tag, "_best_node"}, 64'(nd), 64'(e.node));
    chk({tag, "_best_run"}, 64'(r), 64'(e.run));
    chk({tag, "_runs_completed"}, 64'(rc), 64'(e.rc));
    chk({tag, "_aborted"}, 64'(ab), 64'(e.ab));
    chk({tag, "_err"}, 64'(er), 64'(e.er));
  endtask

  // Node array models: done pulse dly cycles after start, cost from run id or table.
  initial begin
    int            cnt [N];
    int            cntb [N];
    logic [CW-1:0] pc [N];
    logic [CW-1:0] pcb [N];
    for (int n = 0; n < N; n++) begin
      cnt[n] = 0; cntb[n] = 0; pc[n] = '0; pcb[n] = '0;
    end
    node_done = '0; node_cost = '0; node_done_b = '0; node_cost_b = '0;
    forever begin
      @(negedge clk);
      node_done   = spur_req;
      node_done_b = '0;
      for (int n = 0; n < N; n++) begin
        if (!rst_n) begin
          cnt[n] = 0; cntb[n] = 0;
        end else begin
          if (cnt[n] > 0) begin
            cnt[n]--;
            if (cnt[n] == 0) begin
              node_done[n] = 1'b1;
              node_cost[n*CW +: CW] = pc[n];
            end
          end
          if (cntb[n] > 0) begin
            cntb[n]--;
            if (cntb[n] == 0) begin
              node_done_b[n] = 1'b1;
              node_cost_b[n*CW +: CW] = pcb[n];
            end
          end
          if (node_start[n]) begin
            cnt[n] = dly[n];
            pc[n]  = use_tab ? ctab[n] : CW'(100 - int'(node_run_id));
          end
          if (node_start_b[n]) begin
            cntb[n] = 2;
            pcb[n]  = CW'(10 + int'(node_run_id_b));
          end
        end
      end
    end
  end

  // Monitors
  initial begin
    disp_t e;
    fin_t  f;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (node_start != '0) begin
          if (disp_q.size() == 0) chk("disp_extra", 64'(node_start), 64'd0);
          else begin
            e = disp_q.pop_front();
            chk("disp_node", 64'(node_start), 64'(e.node_oh));
            chk("disp_mode", 64'(node_mode), 64'(e.mode));
            chk("disp_run", 64'(node_run_id), 64'(e.run));
          end
        end
        if (done) begin
          done_cnt++;
          if (fin_q.size() == 0) chk("done_extra", 64'(done), 64'd0);
          else begin
            f = fin_q.pop_front();
            chk_fin("fin", f, best_cost, best_node, best_run, runs_completed, aborted, err);
          end
        end
        if (phase_b == 2'd1) seen_b_phase1 = 1'b1;
        if (node_start_b != '0) begin
          if (disp_qb.size() == 0) chk("b_disp_extra", 64'(node_start_b), 64'd0);
          else begin
            e = disp_qb.pop_front();
            chk("b_disp_node", 64'(node_start_b), 64'(e.node_oh));
            chk("b_disp_mode", 64'(node_mode_b), 64'(e.mode));
            chk("b_disp_run", 64'(node_run_id_b), 64'(e.run));
          end
        end
        if (done_b) begin
          done_cnt_b++;
          if (fin_qb.size() == 0) chk("b_done_extra", 64'(done_b), 64'd0);
          else begin
            f = fin_qb.pop_front();
            chk_fin("b_fin", f, best_cost_b, best_node_b, best_run_b, runs_completed_b,
                    aborted_b, err_b);
          end
        end
      end
    end
  end

  task automatic push_disp(input int node, input logic mode, input int run);
    disp_t e;
    e.node_oh = N'(1 << node);
    e.mode    = mode;
    e.run     = RW'(run);
    disp_q.push_back(e);
  endtask

  task automatic push_fin(input int c, input int nd, input int r, input int rc,
                          input logic ab, input logic er);
    fin_t f;
    f.cost = CW'(c); f.node = 6'(nd); f.run = RW'(r); f.rc = (RW+1)'(rc);
    f.ab = ab; f.er = er;
    fin_q.push_back(f);
  endtask

  // Uniform node timing keeps nodes freeing in index order through each phase.
  task automatic push_full_run();
    for (int r = 0; r < 16; r++) begin
      if (r < 6) push_disp(r % 4, 1'b0, r);
      else       push_disp((r - 6) % 4, 1'b1, r);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int seen0;
    bit got;
    seen0 = done_cnt;
    got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(posedge clk); #1;
      if (done_cnt > seen0) got = 1'b1;
    end
    chk(name, 64'(got), 64'd1);
  endtask

  initial begin
    int   nst;
    bit   got;
    logic any_start;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    spur_req = '0; use_tab = 1'b0;
    for (int n = 0; n < N; n++) begin dly[n] = 3; ctab[n] = '0; end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_phase", 64'(phase), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_best_cost", 64'(best_cost), 64'hFFFFFF);
    chk("rst_runs_completed", 64'(runs_completed), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_node_start", 64'(node_start), 64'd0);
    rst_n = 1'b1;

    // init-less instance: improvement runs from run 0
    for (int r = 0; r < 3; r++) begin
      disp_t e;
      e.node_oh = N'(1 << r); e.mode = 1'b1; e.run = RW'(r);
      disp_qb.push_back(e);
    end
    begin
      fin_t f;
      f.cost = CW'(10); f.node = 6'd0; f.run = '0; f.rc = (RW+1)'(3); f.ab = 1'b0; f.er = 1'b0;
      fin_qb.push_back(f);
    end
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      if (done_cnt_b > 0) got = 1'b1;
    end
    chk("b_done_seen", 64'(got), 64'd1);

    // full run, cost 100-run_id
    push_full_run();
    push_fin(85, 1, 15, 16, 1'b0, 1'b0);
    pulse_start();
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_done("full_done_seen");
    @(posedge clk); #1;
    chk("idle_after_done", 64'(busy), 64'd0);

    // simultaneous dones with cost table 50,40,40,60; ties keep the earlier node
    use_tab = 1'b1;
    ctab[0] = 24'd50; ctab[1] = 24'd40; ctab[2] = 24'd40; ctab[3] = 24'd60;
    for (int n = 0; n < N; n++) dly[n] = 6 - n;
    push_full_run();
    push_fin(40, 1, 1, 16, 1'b0, 1'b0);
    pulse_start();
    wait_done("tie_done_seen");
    use_tab = 1'b0;
    for (int n = 0; n < N; n++) dly[n] = 3;

    // abort after three starts
    for (int r = 0; r < 3; r++) push_disp(r, 1'b0, r);
    push_fin(98, 2, 2, 3, 1'b1, 1'b0);
    pulse_start();
    nst = 0;
    for (int i = 0; i < 50 && nst < 3; i++) begin
      if (node_start != '0) nst++;
      if (nst < 3) begin @(posedge clk); #1; end
    end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done("abort_done_seen");
    @(posedge clk); #1;
    chk("aborted_level_idle", 64'(aborted), 64'd1);

    // spurious done on idle node 2
    spur_req = 4'b0100;
    @(posedge clk); #1 spur_req = '0;
    @(posedge clk); #1;
    chk("spur_err", 64'(err), 64'd1);
    chk("spur_runs_completed", 64'(runs_completed), 64'd3);
    push_disp(0, 1'b0, 0);
    push_fin(100, 0, 0, 1, 1'b1, 1'b0);
    pulse_start();
    chk("err_cleared_by_start", 64'(err), 64'd0);
    chk("aborted_cleared_by_start", 64'(aborted), 64'd0);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done("abort1_done_seen");
    chk("disp_q_drained", 64'(disp_q.size()), 64'd0);
    chk("fin_q_drained", 64'(fin_q.size()), 64'd0);
    chk("b_never_init_phase", 64'(seen_b_phase1), 64'd0);

    // reset in the improvement phase
    push_full_run();
    pulse_start();
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      if (phase == 2'd2) got = 1'b1;
    end
    chk("reach_impr", 64'(got), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_phase", 64'(phase), 64'd0);
    chk("midrst_best_cost", 64'(best_cost), 64'hFFFFFF);
    chk("midrst_best_run", 64'(best_run), 64'd0);
    chk("midrst_runs_completed", 64'(runs_completed), 64'd0);
    chk("midrst_node_start", 64'(node_start), 64'd0);
    disp_q.delete();
    fin_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    any_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      any_start = any_start | (|node_start);
    end
    chk("no_start_after_reset", 64'(any_start), 64'd0);
    chk("idle_after_reset", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
